// File: rtl/xpt_sequencer.sv
// ============================================================================
// Module   : xpt_sequencer
// Brief    : Phase counter (XPT), instruction table and cycle-mode sequencer.
//            Optional macro XPT_WAIT_EN adds a WAIT input that stalls a step.
// Revision : 1.0
// ============================================================================
`default_nettype none

module xpt_sequencer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       STEP,
    input  logic       PR_Reset_XPT,
    input  logic [7:0] P2_Set_ITABLE,
    input  logic       P2_Reset_ITABLE,
    input  logic       P2_Set_CMR,
    input  logic       P2_Set_CM1,
`ifdef XPT_WAIT_EN
    input  logic       WAIT,
`endif
    output logic [3:0] XPT,
    output logic [3:0] notXPT,
    output logic [7:0] ITABLE,
    output logic [7:0] notITABLE,
    output logic       CM1,
    output logic       CMR,
    output logic       XPT_Overflow
);

    localparam logic [3:0] C_XPT_MAX = 4'hF;

    typedef enum logic [0:0] {
        CM_M1 = 1'b0,
        CM_R  = 1'b1
    } cmode_t;

    logic [3:0] r_xpt;
    logic [7:0] r_itable;
    cmode_t     r_mode;
    logic       r_cm1;
    logic       r_cmr;
    logic       r_ovf;

    logic       w_wait;
    logic       w_adv;

`ifdef XPT_WAIT_EN
    assign w_wait = WAIT;
`else
    assign w_wait = 1'b0;
`endif

    // A waited step is dropped entirely: nothing is latched for later replay.
    assign w_adv = STEP & ~w_wait;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_xpt    <= 4'd0;
            r_itable <= 8'd0;
            r_ovf    <= 1'b0;
        end else if (w_adv) begin
            if (PR_Reset_XPT) begin
                r_xpt <= 4'd0;
            end else if (r_xpt == C_XPT_MAX) begin
                r_ovf <= 1'b1;
            end else begin
                r_xpt <= r_xpt + 4'd1;
            end
            r_itable <= (P2_Reset_ITABLE ? 8'd0 : r_itable) | P2_Set_ITABLE;
        end
    end

    // Cycle-mode state machine; one-hot flags are registered alongside the state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_mode <= CM_M1;
            r_cm1  <= 1'b1;
            r_cmr  <= 1'b0;
        end else if (w_adv) begin
            case (r_mode)
                CM_M1: begin
                    if (!P2_Set_CM1 && P2_Set_CMR) begin
                        r_mode <= CM_R;
                        r_cm1  <= 1'b0;
                        r_cmr  <= 1'b1;
                    end
                end
                CM_R: begin
                    if (P2_Set_CM1) begin
                        r_mode <= CM_M1;
                        r_cm1  <= 1'b1;
                        r_cmr  <= 1'b0;
                    end
                end
                default: begin
                    r_mode <= CM_M1;
                    r_cm1  <= 1'b1;
                    r_cmr  <= 1'b0;
                end
            endcase
        end
    end

    assign XPT          = r_xpt;
    assign notXPT       = ~r_xpt;
    assign ITABLE       = r_itable;
    assign notITABLE    = ~r_itable;
    assign CM1          = r_cm1;
    assign CMR          = r_cmr;
    assign XPT_Overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_xpt_sequencer.sv
// ============================================================================
// Module   : tb_xpt_sequencer
// Brief    : Directed self-checking bench for xpt_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_xpt_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       STEP = 1'b0;
    logic       PR_Reset_XPT = 1'b0;
    logic [7:0] P2_Set_ITABLE = 8'd0;
    logic       P2_Reset_ITABLE = 1'b0;
    logic       P2_Set_CMR = 1'b0;
    logic       P2_Set_CM1 = 1'b0;
`ifdef XPT_WAIT_EN
    logic       WAIT = 1'b0;
`endif
    logic [3:0] XPT;
    logic [3:0] notXPT;
    logic [7:0] ITABLE;
    logic [7:0] notITABLE;
    logic       CM1;
    logic       CMR;
    logic       XPT_Overflow;

    int checks = 0;
    int failures = 0;

    xpt_sequencer dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .STEP           (STEP),
        .PR_Reset_XPT   (PR_Reset_XPT),
        .P2_Set_ITABLE  (P2_Set_ITABLE),
        .P2_Reset_ITABLE(P2_Reset_ITABLE),
        .P2_Set_CMR     (P2_Set_CMR),
        .P2_Set_CM1     (P2_Set_CM1),
`ifdef XPT_WAIT_EN
        .WAIT           (WAIT),
`endif
        .XPT            (XPT),
        .notXPT         (notXPT),
        .ITABLE         (ITABLE),
        .notITABLE      (notITABLE),
        .CM1            (CM1),
        .CMR            (CMR),
        .XPT_Overflow   (XPT_Overflow)
    );

    initial begin
        #10;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one edge worth of inputs, sample 1 time unit after the rising edge.
    task automatic drive_edge(input logic step, input logic pr, input logic [7:0] set_it,
                              input logic rst_it, input logic cmr, input logic cm1);
        @(negedge CLK);
        STEP = step; PR_Reset_XPT = pr; P2_Set_ITABLE = set_it;
        P2_Reset_ITABLE = rst_it; P2_Set_CMR = cmr; P2_Set_CM1 = cm1;
        @(posedge CLK);
        #1;
        STEP = 1'b0; PR_Reset_XPT = 1'b0; P2_Set_ITABLE = 8'd0;
        P2_Reset_ITABLE = 1'b0; P2_Set_CMR = 1'b0; P2_Set_CM1 = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        RESET = 1'b1;
        #2;
        checks++; if (XPT !== 4'h0) begin failures++; $display("FAIL reset_xpt got=%h exp=0", XPT); end
        checks++; if (notXPT !== 4'hF) begin failures++; $display("FAIL reset_notxpt got=%h exp=F", notXPT); end
        checks++; if (ITABLE !== 8'h00) begin failures++; $display("FAIL reset_itable got=%h exp=00", ITABLE); end
        checks++; if (notITABLE !== 8'hFF) begin failures++; $display("FAIL reset_notitable got=%h exp=FF", notITABLE); end
        checks++; if ({CM1, CMR} !== 2'b10) begin failures++; $display("FAIL reset_cmode got=%b exp=10", {CM1, CMR}); end
        checks++; if (XPT_Overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", XPT_Overflow); end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_count();
        logic [3:0] exp_x;
        for (int i = 1; i <= 7; i++) begin
            drive_edge(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            exp_x = 4'(i);
            checks++; if (XPT !== exp_x || notXPT !== ~exp_x) begin failures++; $display("FAIL count_xpt step=%0d got=%h/%h exp=%h", i, XPT, notXPT, exp_x); end
            checks++; if (XPT_Overflow !== 1'b0) begin failures++; $display("FAIL count_ovf step=%0d got=%b exp=0", i, XPT_Overflow); end
        end
        drive_edge(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (XPT !== 4'h0 || XPT_Overflow !== 1'b0) begin failures++; $display("FAIL count_prreset got=%h ovf=%b exp=0 ovf=0", XPT, XPT_Overflow); end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_x;
        logic       exp_o;
        for (int i = 1; i <= 20; i++) begin
            drive_edge(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            exp_x = (i >= 15) ? 4'hF : 4'(i);
            exp_o = (i >= 16);
            checks++; if (XPT !== exp_x || notXPT !== ~exp_x) begin failures++; $display("FAIL sat_xpt step=%0d got=%h exp=%h", i, XPT, exp_x); end
            checks++; if (XPT_Overflow !== exp_o) begin failures++; $display("FAIL sat_ovf step=%0d got=%b exp=%b", i, XPT_Overflow, exp_o); end
        end
        drive_edge(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (XPT !== 4'h0) begin failures++; $display("FAIL sat_prreset_xpt got=%h exp=0", XPT); end
        checks++; if (XPT_Overflow !== 1'b1) begin failures++; $display("FAIL sat_sticky_ovf got=%b exp=1", XPT_Overflow); end
        pulse_reset();
        checks++; if (XPT_Overflow !== 1'b0) begin failures++; $display("FAIL sat_ovf_cleared got=%b exp=0", XPT_Overflow); end
    endtask

    task automatic test_itable();
        drive_edge(1'b1, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
        checks++; if (ITABLE !== 8'h0F) begin failures++; $display("FAIL it_set got=%h exp=0F", ITABLE); end
        drive_edge(1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
        checks++; if (ITABLE !== 8'h01 || notITABLE !== 8'hFE) begin failures++; $display("FAIL it_reset_set got=%h/%h exp=01/FE", ITABLE, notITABLE); end
        drive_edge(1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
        checks++; if (ITABLE !== 8'h81 || notITABLE !== 8'h7E) begin failures++; $display("FAIL it_accum got=%h/%h exp=81/7E", ITABLE, notITABLE); end
        drive_edge(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (ITABLE !== 8'h00) begin failures++; $display("FAIL it_clear got=%h exp=00", ITABLE); end
    endtask

    task automatic test_cmode();
        logic [3:0] x0;
        drive_edge(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if ({CM1, CMR} !== 2'b01) begin failures++; $display("FAIL cm_set_r got=%b exp=01", {CM1, CMR}); end
        drive_edge(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        checks++; if ({CM1, CMR} !== 2'b10) begin failures++; $display("FAIL cm_both got=%b exp=10", {CM1, CMR}); end
        drive_edge(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        x0 = XPT;
        drive_edge(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        checks++; if ({CM1, CMR} !== 2'b01) begin failures++; $display("FAIL cm_nostep got=%b exp=01", {CM1, CMR}); end
        checks++; if (XPT !== x0 || ITABLE !== 8'h00) begin failures++; $display("FAIL nostep_hold xpt=%h it=%h exp=%h/00", XPT, ITABLE, x0); end
        drive_edge(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if ({CM1, CMR} !== 2'b01) begin failures++; $display("FAIL cm_hold got=%b exp=01", {CM1, CMR}); end
    endtask

    task automatic test_async_reset();
        drive_edge(1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0);
        // Assert mid-cycle, between edges, with requests pending.
        @(negedge CLK);
        #2;
        STEP = 1'b1; P2_Set_ITABLE = 8'hAA; P2_Set_CMR = 1'b1;
        RESET = 1'b1;
        #1;
        checks++; if (XPT !== 4'h0 || ITABLE !== 8'h00 || {CM1, CMR} !== 2'b10) begin failures++; $display("FAIL async_reset xpt=%h it=%h cm=%b exp=0/00/10", XPT, ITABLE, {CM1, CMR}); end
        @(posedge CLK);
        #1;
        checks++; if (XPT !== 4'h0 || ITABLE !== 8'h00 || notITABLE !== 8'hFF) begin failures++; $display("FAIL reset_vs_step xpt=%h it=%h exp=0/00", XPT, ITABLE); end
        @(negedge CLK);
        RESET = 1'b0;
        STEP = 1'b0; P2_Set_ITABLE = 8'h00; P2_Set_CMR = 1'b0;
        drive_edge(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (XPT !== 4'h1 || ITABLE !== 8'h00 || {CM1, CMR} !== 2'b10) begin failures++; $display("FAIL post_reset_step xpt=%h it=%h cm=%b exp=1/00/10", XPT, ITABLE, {CM1, CMR}); end
    endtask

`ifdef XPT_WAIT_EN
    task automatic test_wait();
        pulse_reset();
        for (int i = 0; i < 3; i++) drive_edge(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        WAIT = 1'b1; STEP = 1'b1; P2_Set_ITABLE = 8'h80; P2_Set_CMR = 1'b1;
        @(posedge CLK);
        #1;
        WAIT = 1'b0; STEP = 1'b0; P2_Set_ITABLE = 8'h00; P2_Set_CMR = 1'b0;
        checks++; if (XPT !== 4'h3 || ITABLE !== 8'h00 || {CM1, CMR} !== 2'b10) begin failures++; $display("FAIL wait_hold xpt=%h it=%h cm=%b exp=3/00/10", XPT, ITABLE, {CM1, CMR}); end
        drive_edge(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (XPT !== 4'h4 || ITABLE !== 8'h00) begin failures++; $display("FAIL wait_release xpt=%h it=%h exp=4/00", XPT, ITABLE); end
    endtask
`endif

    initial begin
        test_reset();
        test_count();
        test_saturate();
        test_itable();
        test_cmode();
        test_async_reset();
`ifdef XPT_WAIT_EN
        test_wait();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
